// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed scan driver for a 4-digit common-anode seven-segment
//   display. The four active-low segment bytes and the brightness value are
//   latched once per frame, at slot 0 / count 0. This keeps a frame from
//   mixing old and new data. Each digit slot opens with a blanking gap to
//   suppress ghosting. It then runs a 16-step PWM window for brightness.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      1 = scanning; 0 = blanked, scan position parked at frame start
//   digit0..3   active-low segment bytes (bit 7 = DP), digit0 is rightmost
//   brightness  PWM duty, 0 = off, 15 = fully on
//   segOut      shared active-low segment bus (registered)
//   anodeOut    digit enables, one-hot when lit (registered)
//   frameStart  one-cycle pulse on the first output cycle of each frame
//
// Scan position
//   slot | meaning
//   0..3 | digit currently owning the bus; advances after DWELL_CYCLES
//   cnt  | cycle within slot; < BLANK_CYCLES is the blanking gap
//
// Outputs lag the scan position by one register stage. Segments and anodes
// are driven from the same registered decision, so they always switch on the
// same edge.

module seven_seg_scanner #(
   parameter int DWELL_CYCLES     = 1000,
   parameter int BLANK_CYCLES     = 16,
   parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] digit0,
   input  logic [7:0] digit1,
   input  logic [7:0] digit2,
   input  logic [7:0] digit3,
   input  logic [3:0] brightness,
   output logic [7:0] segOut,
   output logic [3:0] anodeOut,
   output logic       frameStart
);

   // At least 4 bits so the PWM phase can always be taken from the count.
   localparam int            CW        = (DWELL_CYCLES > 16) ? $clog2(DWELL_CYCLES) : 4;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [3:0]    ANODE_OFF = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;

   logic [1:0]    slot;
   logic [CW-1:0] cnt;
   logic [7:0]    shadow [4];
   logic [3:0]    bright_sh;

   logic          frame_origin;
   logic [3:0]    pwm_phase;
   logic          lit;
   logic [3:0]    onehot;
   logic [7:0]    seg_nxt;
   logic [3:0]    anode_nxt;

   always_comb begin
      frame_origin = enable && (slot == 2'd0) && (cnt == '0);
      // Only meaningful once cnt >= BLANK_END; the low 4 bits give mod 16.
      pwm_phase    = 4'(cnt - BLANK_END);
      lit          = enable && (cnt >= BLANK_END) &&
                     ((bright_sh == 4'hF) || (pwm_phase < bright_sh));
      onehot       = 4'b0001 << slot;
      seg_nxt      = 8'hFF;
      anode_nxt    = ANODE_OFF;
      if (lit) begin
         seg_nxt   = shadow[slot];
         anode_nxt = ANODE_ACTIVE_LOW ? ~onehot : onehot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot      <= 2'd0;
         cnt       <= '0;
         bright_sh <= 4'h0;
         for (int i = 0; i < 4; i++) shadow[i] <= 8'hFF;
      end else if (!enable) begin
         slot <= 2'd0;
         cnt  <= '0;
      end else begin
         if (frame_origin) begin
            shadow[0] <= digit0;
            shadow[1] <= digit1;
            shadow[2] <= digit2;
            shadow[3] <= digit3;
            bright_sh <= brightness;
         end
         if (cnt == CNT_LAST) begin
            cnt  <= '0;
            slot <= slot + 2'd1;
         end else begin
            cnt  <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segOut     <= 8'hFF;
         anodeOut   <= ANODE_OFF;
         frameStart <= 1'b0;
      end else begin
         segOut     <= seg_nxt;
         anodeOut   <= anode_nxt;
         frameStart <= frame_origin;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner. Three builds share one stimulus set:
//   u_a : DWELL=8,  BLANK=2, active-low anodes
//   u_b : DWELL=40, BLANK=8, active-low anodes
//   u_c : DWELL=8,  BLANK=2, active-high anodes
// Outputs are sampled on the falling edge. The loop index j is the scan
// position whose output is visible at that sample.

module tb_seven_seg_scanner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [7:0] digit0, digit1, digit2, digit3;
   logic [3:0] brightness;

   logic [7:0] seg_a, seg_b, seg_c;
   logic [3:0] an_a, an_b, an_c;
   logic       fs_a, fs_b, fs_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seven_seg_scanner #(.DWELL_CYCLES(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
      .brightness(brightness), .segOut(seg_a), .anodeOut(an_a), .frameStart(fs_a));

   seven_seg_scanner #(.DWELL_CYCLES(40), .BLANK_CYCLES(8), .ANODE_ACTIVE_LOW(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
      .brightness(brightness), .segOut(seg_b), .anodeOut(an_b), .frameStart(fs_b));

   seven_seg_scanner #(.DWELL_CYCLES(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
      .brightness(brightness), .segOut(seg_c), .anodeOut(an_c), .frameStart(fs_c));

   logic [3:0] an_lo [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] an_hi [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [7:0] dig   [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic do_reset(input logic [3:0] bright);
      rst_n      = 1'b0;
      enable     = 1'b1;
      digit0     = dig[0];
      digit1     = dig[1];
      digit2     = dig[2];
      digit3     = dig[3];
      brightness = bright;
      @(negedge clk);
      @(negedge clk);
      chk("rst_a", {31'(fs_a), an_a, seg_a}, {1'b0, 4'hF, 8'hFF});
      chk("rst_c", {31'(fs_c), an_c, seg_c}, {1'b0, 4'h0, 8'hFF});
      rst_n = 1'b1;
   endtask

   initial begin
      int         s, c, f, n, lit_cnt;
      logic       lit, efs;
      logic [7:0] eseg;

      // Basic scan (both anode polarities) with a mid-frame digit2 change.
      do_reset(4'hF);
      for (int j = 0; j < 77; j++) begin
         @(negedge clk);
         s    = (j / 8) % 4;
         c    = j % 8;
         lit  = (c >= 2);
         efs  = (j % 32 == 0);
         eseg = !lit ? 8'hFF : (s == 2 && j >= 32) ? 8'h99 : dig[s];
         chk($sformatf("scan_a j%0d", j), {fs_a, an_a, seg_a},
             {efs, lit ? an_lo[s] : 4'hF, eseg});
         chk($sformatf("scan_c j%0d", j), {fs_c, an_c, seg_c},
             {efs, lit ? an_hi[s] : 4'h0, eseg});
         if (j == 10) digit2 = 8'h99;
      end

      // Asynchronous reset between edges while slot 1 is lit.
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_a", {fs_a, an_a, seg_a}, {1'b0, 4'hF, 8'hFF});
      chk("async_rst_c", {fs_c, an_c, seg_c}, {1'b0, 4'h0, 8'hFF});
      @(negedge clk);
      rst_n = 1'b1;
      n = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n++;
         if (fs_a) break;
      end
      chk("fs_after_rst", n, 2);

      // PWM on the DWELL=40/BLANK=8 build, brightness 4 -> 0 -> 15.
      do_reset(4'h4);
      lit_cnt = 0;
      for (int j = 0; j < 480; j++) begin
         @(negedge clk);
         f = j / 160;
         s = (j / 40) % 4;
         c = j % 40;
         case (f)
            0:       lit = (c >= 8 && c < 12) || (c >= 24 && c < 28);
            1:       lit = 1'b0;
            default: lit = (c >= 8);
         endcase
         if (f == 0 && s == 0 && an_b != 4'hF) lit_cnt++;
         chk($sformatf("pwm j%0d", j), {fs_b, an_b, seg_b},
             {(j % 160 == 0), lit ? an_lo[s] : 4'hF, lit ? dig[s] : 8'hFF});
         if (j == 50)  brightness = 4'h0;
         if (j == 200) brightness = 4'hF;
      end
      chk("pwm_lit_count", lit_cnt, 8);

      // Enable drop while scan position is slot 2, cnt 5.
      do_reset(4'hF);
      for (int j = 0; j < 21; j++) @(negedge clk);
      chk("pre_drop", {fs_a, an_a, seg_a}, {1'b0, 4'b1011, 8'hA4});
      enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("disabled k%0d", k), {fs_a, an_a, seg_a}, {1'b0, 4'hF, 8'hFF});
      end
      digit0 = 8'h92;
      enable = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         lit = (j >= 2);
         chk($sformatf("reenable j%0d", j), {fs_a, an_a, seg_a},
             {(j == 0), lit ? 4'b1110 : 4'hF, lit ? 8'h92 : 8'hFF});
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed scan driver for a 4-digit common-anode seven-segment display.
- Sits directly downstream of SevenSegWord. It consumes the four active-low segment bytes (bit 7 = DP, 1 = off) and drives one shared segment bus plus four digit enables.
- Latches its inputs once per frame so the display never tears.
- Inserts a blanking gap between digits to suppress ghosting.
- Applies 4-bit PWM brightness.

Parameters:
DWELL_CYCLES, 1000, clock cycles per digit slot; must be >= BLANK_CYCLES+1
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; legal range 1..DWELL_CYCLES-1
ANODE_ACTIVE_LOW, 1, 1: anodeOut bit = 0 enables the digit; 0: bit = 1 enables it

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  1 = scanning; 0 = display blanked and scan state held at frame start
digit0  input  8  active-low segment pattern for digit 0 (rightmost)
digit1  input  8  active-low segment pattern for digit 1
digit2  input  8  active-low segment pattern for digit 2
digit3  input  8  active-low segment pattern for digit 3
brightness  input  4  PWM duty; 0 = off, 15 = fully on
segOut  output  8  shared active-low segment bus
anodeOut  output  4  digit enables, one-hot when active; polarity set by ANODE_ACTIVE_LOW
frameStart  output  1  one-cycle pulse marking the first output cycle of each frame

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n).
- Reset state:
  - slot=0, cnt=0, shadow registers = 8'hFF, brightShadow=0.
  - segOut=8'hFF, anodeOut=all-off (4'hF when ANODE_ACTIVE_LOW=1, else 4'h0), frameStart=0.
  - These values apply immediately on rst_n falling, including mid-frame.
- State:
  - slot (2 bits) and cnt (0..DWELL_CYCLES-1).
  - cnt increments every enabled cycle. At DWELL_CYCLES-1 it wraps to 0 and slot increments; slot wraps 3 -> 0.
  - A frame is 4*DWELL_CYCLES cycles.
- Frame latch: in any enabled cycle with slot=0 and cnt=0, shadow0..3 <= digit0..3 and brightShadow <= brightness. Inputs are ignored at all other times.
- Output timing:
  - All outputs are registered. Outputs in cycle t+1 are a function of the state and shadows at the end of cycle t.
  - Latency from state to pins is therefore 1 cycle.
- Blank phase (cnt < BLANK_CYCLES): segOut=8'hFF, anodes all off.
  - Because BLANK_CYCLES >= 1, the shadow load never coincides with a lit output.
- Active phase (cnt >= BLANK_CYCLES):
  - p = (cnt - BLANK_CYCLES) mod 16.
  - The digit is lit iff brightShadow==15 or p < brightShadow.
  - Lit: segOut=shadow[slot], anodeOut = one-hot on bit slot.
  - Not lit: segOut=8'hFF, anodes all off.
- frameStart = 1 in the output cycle that follows an enabled state with (slot,cnt)=(0,0); 0 otherwise.
- Segment bus and anodes change on the same edge. Anodes are never on while segOut holds data belonging to a different slot.
- enable=0:
  - Next output cycle is blank with frameStart=0.
  - slot and cnt are forced to 0; shadows hold their values.
  - The first enabled cycle after re-assertion is treated as (0,0): shadows reload, frameStart pulses one cycle later.
- Inputs are assumed synchronous to clk; no internal synchronisers.

Test Plan:
1. Reset mid-scan (DWELL=8, BLANK=2, digits scanning) -> drop rst_n asynchronously between edges -> segOut=8'hFF and anodeOut=4'hF immediately, frameStart=0; after release, first frameStart exactly 2 cycles later.
2. Basic scan: DWELL=8, BLANK=2, brightness=4'hF, digit0..3 = 8'hC0, 8'hF9, 8'hA4, 8'hB0.
   - Each slot gives 2 blank cycles, then 6 cycles of anodeOut = 4'b1110 / 4'b1101 / 4'b1011 / 4'b0111 with segOut = C0 / F9 / A4 / B0.
   - frameStart pulses every 32 cycles.
3. Tear-free latch: during slot 1 of a frame, change digit2 from 8'hA4 to 8'h99 -> slot 2 of the same frame still shows 8'hA4; slot 2 of the next frame shows 8'h99.
4. PWM duty with DWELL=40, BLANK=8:
   - brightness=4 -> per slot, lit only for active offsets 0-3 and 16-19 (8 cycles).
   - brightness=0 -> anodes never on.
   - brightness=15 -> lit all 32 active cycles.
   - A brightness change mid-frame takes effect only at the next frame start.
5. Enable drop at slot 2, cnt 5 -> next output cycle blank; hold enable=0 for 10 cycles (all blank, no frameStart); re-assert -> frameStart one cycle after the first enabled cycle, shadows reloaded from current inputs, slot 0 lit after BLANK_CYCLES.
6. ANODE_ACTIVE_LOW=0 build: repeat scenario 2 -> anodeOut = 4'b0001 / 0010 / 0100 / 1000, all-off = 4'h0, including the reset value.
